logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, registered bitwise logic unit: applies one of 8 opcodes to two WIDTH-bit operands.
//  Adds a valid/ready handshake, a 2-entry output buffer (full throughput under backpressure) and an
//  accumulate mode where operand b is the previous result. Sits between operand producers and result
//  consumers as the sequential successor of the single-bit combinational gate set.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand beat offered
//  in_ready   out  1      unit can accept a beat this cycle
//  in_op      in   3      opcode (table below)
//  in_acc     in   1      1: operand b replaced by acc register
//  in_a       in   WIDTH  operand a
//  in_b       in   WIDTH  operand b (ignored when in_acc=1)
//  out_valid  out  1      result beat available
//  out_ready  in   1      consumer accepts result this cycle
//  out_res    out  WIDTH  result of oldest buffered beat
//  out_par    out  1      XOR-reduction (parity) of out_res
// BEHAVIOUR
//  - Opcodes: 000 AND, 001 OR, 010 NOT a, 011 NAND, 100 NOR, 101 XOR, 110 XNOR, 111 PASS a.
//    Unary ops (010, 111) ignore b. All ops bitwise across WIDTH; no carries.
//  - Beat accepted (push) on rising edge when in_valid && in_ready; result popped when out_valid && out_ready.
//  - Result computed combinationally from inputs, written into the 2-entry FIFO at the push edge.
//  - Latency: beat pushed at edge k -> out_valid=1 with that result from edge k onward (visible in the
//    cycle after k) if buffer was empty. In-order; no beat dropped or duplicated.
//  - in_ready = (count < 2), registered-state derived (no combinational path from out_ready).
//  - count update: push&!pop +1; pop&!push -1; push&pop unchanged (legal only at count=1; at count=2
//    push impossible; at count=0 pop impossible).
//  - out_valid = (count != 0). out_res/out_par hold the head entry stable while out_valid && !out_ready.
//  - Accumulate: acc register (WIDTH) loads the computed result on every push, whether in_acc is 0 or 1.
//    With in_acc=1, b := acc (result of previous accepted beat, or 0 after reset).
//  - in_op, in_a, in_b, in_acc are don't-care when no push occurs; acc does not change without a push.
//  - Reset (async assert, any time, incl. mid-transfer): count=0, FIFO contents=0, acc=0, rd/wr ptrs=0;
//    outputs: in_ready=0 while rst=1, in_ready=1 on first clk after deassert; out_valid=0, out_res=0,
//    out_par=0. Buffered beats are discarded. Deassertion is synchronised by the integrator.
//  - Pointers: 1-bit rd/wr pointers wrap 1->0; full/empty from count, not pointer compare.
// TESTING (WIDTH=8)
//  1 Ops sweep: a=8'hC5, b=8'h3A, out_ready=1, op 0..7 back-to-back -> results 00,FF,3A,FF,00,FF,00,C5;
//    one result per cycle, out_par matches each result's parity.
//  2 Backpressure: out_ready=0, push 3 beats -> in_ready drops after 2 accepts; 3rd held; release
//    out_ready -> results appear in push order, 3rd beat accepted the cycle count reaches 1.
//  3 Simultaneous push/pop at count=1 for 20 cycles -> count stays 1, out_valid continuously 1, no loss.
//  4 Accumulate: push XOR a=8'h01 acc=0, then 4 x {XOR, in_acc=1, a=8'h01} -> 01,00,01,00,01.
//  5 Reset mid-operation: 2 beats buffered, assert rst between clk edges -> out_valid/out_res/out_par
//    drop to 0 immediately; after deassert, first beat with in_acc=1, OR a=0 -> result 00.
//  6 Hold: out_ready=0 with 1 beat buffered, toggle in_a/in_b/in_op with in_valid=0 for 5 cycles ->
//    out_res unchanged.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready handshake, 2-entry result buffer and accumulate mode.
// Latency 1 cycle from push to out_valid; in_ready depends only on registered state, never on out_ready.
module logic_unit_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_par
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [WIDTH-1:0] acc;
    logic             run;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             push;
    logic             pop;

    // run holds in_ready low during reset and until the first clock after release
    assign in_ready  = run && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        opb = in_acc ? acc : in_b;
        res = '0;
        case (in_op)
            3'b000:  res = in_a & opb;
            3'b001:  res = in_a | opb;
            3'b010:  res = ~in_a;
            3'b011:  res = ~(in_a & opb);
            3'b100:  res = ~(in_a | opb);
            3'b101:  res = in_a ^ opb;
            3'b110:  res = ~(in_a ^ opb);
            default: res = in_a;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            acc    <= '0;
            run    <= 1'b0;
        end else begin
            run <= 1'b1;
            if (push) begin
                mem[wr_ptr] <= res;
                wr_ptr      <= ~wr_ptr;
                acc         <= res;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    assign out_res = out_valid ? mem[rd_ptr] : '0;
    assign out_par = ^out_res;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe (WIDTH=8): vector table plus hand-written handshake sequences.
module tb_logic_unit_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic       in_acc;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_res;
    logic       out_par;

    int checks;
    int failures;

    logic [7:0] exp_q[$];
    logic [7:0] cur_exp;
    logic       accepted;

    typedef struct {
        logic [2:0] op;
        logic       acc;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[13];

    logic_unit_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_acc    (in_acc),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_par   (out_par)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~a;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return a ^ b;
            3'd6: return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    // One clock: scoreboard pop/compare and push are sampled at the falling edge.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        accepted = 1'b0;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", out_res, 8'hxx);
            end else begin
                e = exp_q.pop_front();
                chk("out_res", out_res, e);
                chk("out_par", {7'd0, out_par}, {7'd0, ^e});
            end
        end
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(cur_exp);
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic acc, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] e);
        bit got;
        got      = 1'b0;
        in_op    = op;
        in_acc   = acc;
        in_a     = a;
        in_b     = b;
        cur_exp  = e;
        in_valid = 1'b1;
        for (int t = 0; t < 100 && !got; t++) begin
            tick();
            if (accepted) got = 1'b1;
        end
        in_valid = 1'b0;
        if (!got) chk("send_timeout", 8'd0, 8'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && exp_q.size() > 0; t++) tick();
        chk("drain_empty", exp_q.size()[7:0], 8'd0);
    endtask

    initial begin
        logic [2:0] rop;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] held;

        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_acc    = 1'b0;
        in_a      = 8'd0;
        in_b      = 8'd0;
        out_ready = 1'b1;
        cur_exp   = 8'd0;
        accepted  = 1'b0;

        tbl[0]  = '{3'd0, 1'b0, 8'hC5, 8'h3A, 8'h00};
        tbl[1]  = '{3'd1, 1'b0, 8'hC5, 8'h3A, 8'hFF};
        tbl[2]  = '{3'd2, 1'b0, 8'hC5, 8'h3A, 8'h3A};
        tbl[3]  = '{3'd3, 1'b0, 8'hC5, 8'h3A, 8'hFF};
        tbl[4]  = '{3'd4, 1'b0, 8'hC5, 8'h3A, 8'h00};
        tbl[5]  = '{3'd5, 1'b0, 8'hC5, 8'h3A, 8'hFF};
        tbl[6]  = '{3'd6, 1'b0, 8'hC5, 8'h3A, 8'h00};
        tbl[7]  = '{3'd7, 1'b0, 8'hC5, 8'h3A, 8'hC5};
        tbl[8]  = '{3'd5, 1'b0, 8'h01, 8'h00, 8'h01};
        tbl[9]  = '{3'd5, 1'b1, 8'h01, 8'h55, 8'h00};
        tbl[10] = '{3'd5, 1'b1, 8'h01, 8'h55, 8'h01};
        tbl[11] = '{3'd5, 1'b1, 8'h01, 8'h55, 8'h00};
        tbl[12] = '{3'd5, 1'b1, 8'h01, 8'h55, 8'h01};

        // Reset state
        #12;
        chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
        chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_out_res", out_res, 8'd0);
        chk("rst_out_par", {7'd0, out_par}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {7'd0, in_ready}, 8'd1);

        // Ops sweep and accumulate chain, back-to-back
        for (int i = 0; i < 13; i++) begin
            send(tbl[i].op, tbl[i].acc, tbl[i].a, tbl[i].b, tbl[i].exp);
            chk("sweep_valid", {7'd0, out_valid}, 8'd1);
        end
        drain();

        // Backpressure: two accepts, third held until a slot frees
        out_ready = 1'b0;
        send(3'd1, 1'b0, 8'h10, 8'h01, 8'h11);
        send(3'd0, 1'b0, 8'hF0, 8'h3C, 8'h30);
        chk("bp_full_ready", {7'd0, in_ready}, 8'd0);
        in_op    = 3'd2;
        in_acc   = 1'b0;
        in_a     = 8'h0F;
        in_b     = 8'h00;
        cur_exp  = 8'hF0;
        in_valid = 1'b1;
        tick();
        tick();
        chk("bp_held_ready", {7'd0, in_ready}, 8'd0);
        chk("bp_head", out_res, 8'h11);
        out_ready = 1'b1;
        tick();
        chk("bp_ready_after_pop", {7'd0, in_ready}, 8'd1);
        tick();
        chk("bp_third_accepted", {7'd0, accepted}, 8'd1);
        in_valid = 1'b0;
        drain();

        // Simultaneous push/pop at count=1
        out_ready = 1'b1;
        for (int i = 0; i < 21; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            send(rop, 1'b0, ra, rb, model(rop, ra, rb));
            chk("pp_valid", {7'd0, out_valid}, 8'd1);
            chk("pp_ready", {7'd0, in_ready}, 8'd1);
        end
        drain();

        // Hold: head stable while inputs churn with no push
        out_ready = 1'b0;
        send(3'd6, 1'b0, 8'hA5, 8'h0F, 8'h55);
        held = 8'h55;
        for (int i = 0; i < 5; i++) begin
            in_op = 3'($urandom_range(0, 7));
            in_a  = 8'($urandom);
            in_b  = 8'($urandom);
            tick();
            chk("hold_res", out_res, held);
        end
        out_ready = 1'b1;
        drain();

        // Reset mid-operation with two beats buffered and acc nonzero
        out_ready = 1'b0;
        send(3'd7, 1'b0, 8'hFF, 8'h00, 8'hFF);
        send(3'd7, 1'b0, 8'h81, 8'h00, 8'h81);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {7'd0, out_valid}, 8'd0);
        chk("mid_rst_res", out_res, 8'd0);
        chk("mid_rst_par", {7'd0, out_par}, 8'd0);
        chk("mid_rst_ready", {7'd0, in_ready}, 8'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ready", {7'd0, in_ready}, 8'd1);
        chk("post_rst_valid", {7'd0, out_valid}, 8'd0);
        out_ready = 1'b1;
        send(3'd1, 1'b1, 8'h00, 8'hFF, 8'h00);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
